// File: rtl/crc64_checker_if.sv
// Register bus and framed word stream of the CRC-64 signature checker.
// Also carries the check result outputs.
interface crc64_checker_if;
    logic        write;
    logic        read;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic        in_eof;
    logic [9:0]  bits_stream;
    logic        crc_done;
    logic        crc_ok;
    logic [63:0] crc_value;

    modport master (
        output write, read, addr, wdata, in_valid, in_sof, in_eof, bits_stream,
        input  rdata, in_ready, crc_done, crc_ok, crc_value
    );

    modport slave (
        input  write, read, addr, wdata, in_valid, in_sof, in_eof, bits_stream,
        output rdata, in_ready, crc_done, crc_ok, crc_value
    );
endinterface

// File: rtl/crc64_checker.sv
// Receive-side CRC-64/ECMA-182 signature checker: ten serial steps per word,
// end-of-frame compare against a programmed value, results on the register bus.
module crc64_checker #(
    parameter logic [11:0] SEED_LO_ADDR = 12'h070,
    parameter int          CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    crc64_checker_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a sof word; non-sof words are dropped
    // ACCUM | inside a frame, folding words into the signature
    // CHECK | one-cycle compare against expected; input stalled
    typedef enum logic [1:0] {IDLE, ACCUM, CHECK} state_t;

    localparam logic [63:0] POLY = 64'h42F0E1EBA9EA3693;

    state_t            state, state_nxt;
    logic [63:0]       crc_value, crc_nxt;
    logic [63:0]       seed, expected;
    logic [CNT_W-1:0]  frame_cnt, err_cnt;
    logic              abort_sticky, abort_set;
    logic              crc_done, crc_ok;
    logic [31:0]       rdata, rd_mux;
    logic [11:0]       off;
    logic              accept, in_ready, clr;

    // Feedback taps on s[63] only; the data bit enters at bit 0 alone.
    function automatic logic [63:0] step10(input logic [63:0] s_in, input logic [9:0] w);
        logic [63:0] s;
        logic [63:0] nx;
        s = s_in;
        for (int i = 0; i < 10; i++) begin
            nx[0] = s[63] ^ w[i];
            for (int k = 1; k < 64; k++)
                nx[k] = s[k-1] ^ (s[63] & POLY[k]);
            s = nx;
        end
        return s;
    endfunction

    assign in_ready = (state != CHECK);
    assign accept   = bus.in_valid & in_ready;
    assign off      = bus.addr - SEED_LO_ADDR;
    assign clr      = bus.write && (off == 12'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            crc_value <= '0;
        end else begin
            state     <= state_nxt;
            crc_value <= crc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc_value;
        abort_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && bus.in_sof) begin
                    crc_nxt   = step10(seed, bus.bits_stream);
                    state_nxt = bus.in_eof ? CHECK : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        crc_nxt   = step10(seed, bus.bits_stream);
                        abort_set = 1'b1;
                    end else begin
                        crc_nxt = step10(crc_value, bus.bits_stream);
                    end
                    if (bus.in_eof) state_nxt = CHECK;
                end
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status clear takes priority over a simultaneous CHECK-exit update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_done     <= 1'b0;
            crc_ok       <= 1'b0;
            frame_cnt    <= '0;
            err_cnt      <= '0;
            abort_sticky <= 1'b0;
        end else begin
            crc_done <= (state == CHECK);
            if (state == CHECK) crc_ok <= (crc_value == expected);
            if (clr) begin
                frame_cnt    <= '0;
                err_cnt      <= '0;
                abort_sticky <= 1'b0;
            end else begin
                if (abort_set) abort_sticky <= 1'b1;
                if (state == CHECK) begin
                    if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
                    if ((crc_value != expected) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            12'd0: rd_mux = seed[31:0];
            12'd1: rd_mux = seed[63:32];
            12'd2: rd_mux = expected[31:0];
            12'd3: rd_mux = expected[63:32];
            12'd4: rd_mux = {16'(frame_cnt), 13'd0, abort_sticky, crc_ok, (state != IDLE)};
            12'd5: rd_mux = 32'(err_cnt);
            12'd6: rd_mux = crc_value[31:0];
            12'd7: rd_mux = crc_value[63:32];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed     <= '0;
            expected <= '0;
            rdata    <= '0;
        end else begin
            if (bus.write) begin
                case (off)
                    12'd0: seed[31:0]      <= bus.wdata;
                    12'd1: seed[63:32]     <= bus.wdata;
                    12'd2: expected[31:0]  <= bus.wdata;
                    12'd3: expected[63:32] <= bus.wdata;
                    default: ;
                endcase
            end
            if (bus.read) rdata <= rd_mux;
        end
    end

    assign bus.rdata     = rdata;
    assign bus.in_ready  = in_ready;
    assign bus.crc_done  = crc_done;
    assign bus.crc_ok    = crc_ok;
    assign bus.crc_value = crc_value;
endmodule

// File: tb/tb_crc64_checker.sv
// Scoreboard bench for crc64_checker: expected signatures are queued when a
// frame's eof is driven and compared when crc_done pulses.
module tb_crc64_checker;
    localparam logic [11:0] BASE = 12'h070;
    localparam logic [63:0] POLY = 64'h42F0E1EBA9EA3693;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc64_checker_if bus();
    crc64_checker #(.SEED_LO_ADDR(BASE), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {logic [63:0] crc; logic ok;} exp_t;
    exp_t sb[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0] m_seed, m_exp, m_crc;
    logic        m_in_frame, m_abort;
    int          m_frames, m_errs;

    function automatic logic [63:0] model_step10(input logic [63:0] s_in, input logic [9:0] w);
        logic [63:0] s;
        logic fb;
        s = s_in;
        for (int i = 0; i < 10; i++) begin
            fb = s[63];
            s = {s[62:0], fb ^ w[i]} ^ (fb ? {POLY[63:1], 1'b0} : 64'd0);
        end
        return s;
    endfunction

    task automatic model_reset();
        m_seed = '0; m_exp = '0; m_crc = '0;
        m_in_frame = 1'b0; m_abort = 1'b0;
        m_frames = 0; m_errs = 0;
        sb.delete();
    endtask

    task automatic reg_write(input logic [2:0] o, input logic [31:0] d);
        @(negedge clk);
        bus.write = 1'b1; bus.addr = BASE + {9'd0, o}; bus.wdata = d;
        @(negedge clk);
        bus.write = 1'b0;
        if (o == 3'd4) begin m_frames = 0; m_errs = 0; m_abort = 1'b0; end
    endtask

    task automatic reg_read(input logic [2:0] o, output logic [31:0] d);
        @(negedge clk);
        bus.read = 1'b1; bus.addr = BASE + {9'd0, o};
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.rdata;
    endtask

    task automatic set_seed(input logic [63:0] s);
        reg_write(3'd0, s[31:0]); reg_write(3'd1, s[63:32]); m_seed = s;
    endtask

    task automatic set_exp(input logic [63:0] e);
        reg_write(3'd2, e[31:0]); reg_write(3'd3, e[63:32]); m_exp = e;
    endtask

    task automatic model_word(input logic sof, input logic eof, input logic [9:0] w);
        if (sof) begin
            if (m_in_frame) m_abort = 1'b1;
            m_crc = model_step10(m_seed, w);
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            m_crc = model_step10(m_crc, w);
        end
        if (eof && m_in_frame) begin
            sb.push_back('{crc: m_crc, ok: (m_crc == m_exp)});
            m_frames++;
            if (m_crc != m_exp) m_errs++;
            m_in_frame = 1'b0;
        end
    endtask

    task automatic send_word(input logic sof, input logic eof, input logic [9:0] w);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sof = sof; bus.in_eof = eof; bus.bits_stream = w;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            total_cnt++;
            $display("FAIL ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        model_word(sof, eof, w);
        #1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.crc_done && n < 10) begin @(negedge clk); n++; end
        total_cnt++;
        if (!bus.crc_done || sb.size() == 0) begin
            $display("FAIL %s_done: crc_done=%b queued=%0d required pulse with entry", name, bus.crc_done, sb.size());
            return;
        end
        pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if (bus.crc_value !== e.crc) $display("FAIL %s_crc: got %h required %h", name, bus.crc_value, e.crc);
        else pass_cnt++;
        total_cnt++;
        if (bus.crc_ok !== e.ok) $display("FAIL %s_ok: got %b required %b", name, bus.crc_ok, e.ok);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.crc_done !== 1'b0) $display("FAIL %s_done_width: crc_done=%b required 0", name, bus.crc_done);
        else pass_cnt++;
    endtask

    task automatic check_status(input string name, input logic ok_req);
        logic [31:0] st, er;
        reg_read(3'd4, st);
        total_cnt++;
        if (st !== {m_frames[15:0], 13'd0, m_abort, ok_req, 1'b0})
            $display("FAIL %s_status: got %h required %h", name, st, {m_frames[15:0], 13'd0, m_abort, ok_req, 1'b0});
        else pass_cnt++;
        reg_read(3'd5, er);
        total_cnt++;
        if (er !== 32'(m_errs)) $display("FAIL %s_err_cnt: got %0d required %0d", name, er, m_errs);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        bus.write = 0; bus.read = 0; bus.addr = '0; bus.wdata = '0;
        bus.in_valid = 0; bus.in_sof = 0; bus.in_eof = 0; bus.bits_stream = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.in_ready, bus.crc_done, bus.crc_ok} !== 3'b100)
            $display("FAIL reset_flags: ready/done/ok=%b required 100", {bus.in_ready, bus.crc_done, bus.crc_ok});
        else pass_cnt++;
        total_cnt++;
        if (bus.crc_value !== 64'd0 || bus.rdata !== 32'd0)
            $display("FAIL reset_values: crc=%h rdata=%h required 0", bus.crc_value, bus.rdata);
        else pass_cnt++;
        reg_read(3'd4, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL reset_status: got %h required 0", d);
        else pass_cnt++;
    endtask

    task automatic test_single();
        set_seed(64'd0);
        set_exp(64'h200);
        send_word(1'b1, 1'b1, 10'h001);
        @(negedge clk);
        total_cnt++;
        if (bus.crc_done !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL single_check_cycle: done=%b ready=%b required 0 0", bus.crc_done, bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.crc_done !== 1'b1 || bus.crc_value !== 64'h200 || bus.crc_ok !== 1'b1)
            $display("FAIL single_n1: done=%b crc=%h ok=%b required 1 200 1", bus.crc_done, bus.crc_value, bus.crc_ok);
        else pass_cnt++;
        void'(sb.pop_front());
        @(negedge clk);
        total_cnt++;
        if (bus.crc_done !== 1'b0) $display("FAIL single_n2: done=%b required 0", bus.crc_done);
        else pass_cnt++;
        check_status("single", 1'b1);
    endtask

    task automatic test_mismatch();
        set_seed(64'd1);
        set_exp(64'h401);
        send_word(1'b1, 1'b1, 10'h000);
        wait_done("mismatch");
        check_status("mismatch", 1'b0);
    endtask

    task automatic test_feedback();
        logic [31:0] lo, hi;
        set_seed(64'h0040000000000000);
        set_exp(64'h42F0E1EBA9EA3693);
        send_word(1'b1, 1'b1, 10'h000);
        wait_done("feedback");
        reg_read(3'd6, lo);
        reg_read(3'd7, hi);
        total_cnt++;
        if ({hi, lo} !== 64'h42F0E1EBA9EA3693) $display("FAIL feedback_readback: got %h required 42f0e1eba9ea3693", {hi, lo});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        set_seed(64'd0);
        set_exp(64'hFFC00);
        @(negedge clk);
        bus.in_valid = 1; bus.in_sof = 1; bus.in_eof = 0; bus.bits_stream = 10'h3FF;
        model_word(1'b1, 1'b0, 10'h3FF);
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_accum: got %b required 1", bus.in_ready);
        else pass_cnt++;
        bus.in_sof = 0; bus.in_eof = 1; bus.bits_stream = 10'h000;
        model_word(1'b0, 1'b1, 10'h000);
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready_check: got %b required 0", bus.in_ready);
        else pass_cnt++;
        bus.in_eof = 0; bus.bits_stream = 10'h155;
        @(negedge clk);
        e = sb.pop_front();
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.crc_done !== 1'b1 || bus.crc_value !== e.crc || bus.crc_ok !== e.ok)
            $display("FAIL b2b_result: ready=%b done=%b crc=%h ok=%b required 1 1 %h %b",
                     bus.in_ready, bus.crc_done, bus.crc_value, bus.crc_ok, e.crc, e.ok);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.crc_done !== 1'b0 || bus.crc_value !== 64'hFFC00)
            $display("FAIL b2b_drop: done=%b crc=%h required 0 00000000000ffc00", bus.crc_done, bus.crc_value);
        else pass_cnt++;
        bus.in_valid = 0;
    endtask

    task automatic test_abort();
        reg_write(3'd4, 32'd0);
        set_seed(64'd0);
        set_exp(64'h200);
        send_word(1'b1, 1'b0, 10'h3FF);
        send_word(1'b1, 1'b1, 10'h001);
        wait_done("abort");
        check_status("abort", 1'b1);
    endtask

    task automatic test_clear_collision();
        logic [31:0] st;
        exp_t e;
        set_exp(64'h1);
        send_word(1'b1, 1'b1, 10'h2A5);
        @(negedge clk);
        bus.write = 1'b1; bus.addr = BASE + 12'd4; bus.wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.write = 1'b0;
        m_frames = 0; m_errs = 0; m_abort = 1'b0;
        e = sb.pop_front();
        total_cnt++;
        if (bus.crc_done !== 1'b1 || bus.crc_value !== e.crc)
            $display("FAIL collide_done: done=%b crc=%h required 1 %h", bus.crc_done, bus.crc_value, e.crc);
        else pass_cnt++;
        reg_read(3'd4, st);
        total_cnt++;
        if (st[31:16] !== 16'd0 || st[2] !== 1'b0)
            $display("FAIL collide_clear: frame_cnt=%0d sticky=%b required 0 0", st[31:16], st[2]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int seen;
        set_seed(64'h0123_4567_89AB_CDEF);
        send_word(1'b1, 1'b0, 10'h0F0);
        send_word(1'b0, 1'b0, 10'h11F);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.crc_value !== 64'd0 || bus.in_ready !== 1'b1)
            $display("FAIL rst_async: crc=%h ready=%b required 0 1", bus.crc_value, bus.in_ready);
        else pass_cnt++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.crc_done) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL rst_no_done: pulses=%0d required 0", seen);
        else pass_cnt++;
        reg_read(3'd0, d);
        total_cnt++;
        if (d !== 32'd0) $display("FAIL rst_seed: got %h required 0", d);
        else pass_cnt++;
        check_status("rst_mid", 1'b0);
    endtask

    task automatic test_status_clear();
        set_seed(64'd0);
        set_exp(64'd5);
        send_word(1'b1, 1'b0, 10'h3FF);
        send_word(1'b1, 1'b1, 10'h013);
        wait_done("preclear");
        check_status("preclear", 1'b0);
        reg_write(3'd4, 32'h1234_5678);
        check_status("cleared", 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_mismatch();
        test_feedback();
        test_back_to_back();
        test_abort();
        test_clear_collision();
        test_reset_mid();
        test_status_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/crc64_checker.md
# crc64_checker

Receive-side signature checker for the 10-bit-per-clock CRC-64 scrambler stream. It accepts framed 10-bit words over a valid/ready handshake and runs the same 64-bit signature register as the transmit-side data selector. At end of frame it compares the result against a software-programmed expected value, then reports pass/fail, counters and the final signature through the 12-bit register bus.

## Interface
Parameters:
- SEED_LO_ADDR, 12'h070: base address. Register map occupies SEED_LO_ADDR+0 … +7.
- CNT_W, 16: width of frame and error counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- write  in  1  register write strobe.
- read  in  1  register read strobe.
- addr  in  12  register address.
- wdata  in  32  register write data.
- rdata  out  32  register read data; registered, 1-cycle latency.
- in_valid  in  1  word present.
- in_ready  out  1  checker accepts word (combinational from state).
- in_sof  in  1  first word of frame.
- in_eof  in  1  last word of frame.
- bits_stream  in  10  payload word; bit 0 is first in time.
- crc_done  out  1  one-cycle pulse, check complete.
- crc_ok  out  1  result of last check; held until next check.
- crc_value  out  64  signature register.

## Operation
- Polynomial: CRC-64/ECMA-182, 0x42F0E1EBA9EA3693, non-reflected, no final XOR.
- Single bit step with state s and input d:
  - next[0] = s[63]^d.
  - next[k] = s[k-1] ^ (s[63] & P[k]) for k = 1..63.
- Ten steps per accepted word, applied in order bits_stream[0] … bits_stream[9].
- Accept = in_valid & in_ready.
- FSM states: IDLE, ACCUM, CHECK.
  - IDLE: in_ready=1.
    - Accept with sof: crc_value <= step10(seed, word); go to ACCUM, or to CHECK if eof is also set.
    - Accept without sof: word dropped, no state change.
  - ACCUM: in_ready=1.
    - Accept: crc_value <= step10(crc_value, word).
    - Accept with eof: go to CHECK.
    - Accept with sof: abort current frame, set abort sticky, restart from seed with this word. Counters unchanged. Eof on the same word still goes to CHECK.
  - CHECK: in_ready=0 for exactly one cycle; then go to IDLE.
    - On exit: crc_ok <= (crc_value == expected); crc_done=1 for one cycle.
    - frame_cnt += 1; err_cnt += 1 if mismatch. Both counters saturate at all-ones.
- Registers (offset from SEED_LO_ADDR):
  - +0/+1 seed lo/hi, R/W.
  - +2/+3 expected lo/hi, R/W.
  - +4 status, read: [31:16] frame_cnt, [2] abort sticky, [1] crc_ok, [0] busy (state≠IDLE).
  - +4 status, write of any value: clears frame_cnt, err_cnt and abort sticky.
  - +5 err_cnt, RO.
  - +6/+7 crc_value lo/hi, RO.
  - Unmapped reads return 0.
- Seed and expected are sampled when used. Seed is sampled at sof accept, expected at CHECK. Writes mid-frame therefore affect only later use points.
- Status clear and a CHECK-exit increment in the same cycle: clear wins, counters end at 0.

## Timing
- Reset values:
  - state IDLE; in_ready 1.
  - crc_value, seed and expected 0.
  - crc_done 0, crc_ok 0.
  - counters 0, abort sticky 0, rdata 0.
- Eof accepted at edge N: state=CHECK after N. After N+1: crc_done=1, crc_ok valid, state IDLE. After N+2: crc_done=0.
- The word after eof can be accepted at earliest on edge N+2.
- Read issued at edge N: rdata valid after N. rdata holds its value when read is low.
- rst asserted mid-frame: immediate return to reset values; the partial frame is discarded with no done pulse.

## Test plan
- Seed 0; single word sof+eof, 0x001; expected 0x200 → crc_value 0x0000000000000200, crc_done one cycle at N+1, crc_ok=1, frame_cnt=1.
- Seed 0x0000000000000001; word 0x000 sof+eof → crc_value 0x400. Expected 0x401 → crc_ok=0, err_cnt=1.
- Seed 0x0040000000000000; word 0x000 → crc_value 0x42F0E1EBA9EA3693 (feedback path exercised).
- Seed 0; words 0x3FF (sof) then 0x000 (eof) → crc_value 0xFFC00. Check in_ready=0 only in the CHECK cycle while in_valid is held high.
- Seed 0; sof 0x3FF, second sof 0x001 with eof → abort sticky=1, crc_value 0x200, frame_cnt=1.
- Assert rst during ACCUM → all reset values, no crc_done. Write to status → counters and sticky read back 0.
